// File: rtl/module_lpf_biquad.sv
// Direct-form-I biquad low-pass section that time-shares an external DSP slice.
// Five products per sample are issued over the shared OR-bus; the result is saturated to Q1.16.
module module_lpf_biquad (
  input  logic        clk,
  input  logic        reset,
  input  logic [89:0] coefs_flat,
  input  logic        coefs_update,
  input  logic [17:0] sample_in,
  input  logic        sample_in_rdy,
  output logic [17:0] sample_out,
  output logic        sample_out_rdy,
  output logic        busy,
  input  logic [47:0] dsp_outs_flat,
  output logic [91:0] dsp_ins_flat
);

  localparam logic [7:0] DSP_XIN_MULT = 8'h01;
  localparam logic [7:0] DSP_ZIN_ZERO = 8'h00;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [89:0] shadow, active;
  logic [17:0] x0, x1, x2, y1, y2;
  logic [47:0] acc;
  logic [2:0]  vld, neg;
  logic [17:0] y_sat, y_hold;
  logic [17:0] op_a, op_b;
  logic        issue, accept;

  assign accept = (state == IDLE) && sample_in_rdy;
  assign issue  = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sample_in_rdy) state_nxt = ISSUE;
      ISSUE:   if (cnt == 3'd4) state_nxt = DRAIN;
      DRAIN:   if (cnt == 3'd2) state_nxt = OUT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (cnt)
      3'd0: begin op_a = active[53:36]; op_b = x0; end
      3'd1: begin op_a = active[35:18]; op_b = x1; end
      3'd2: begin op_a = active[17:0];  op_b = x2; end
      3'd3: begin op_a = active[89:72]; op_b = y1; end
      default: begin op_a = active[71:54]; op_b = y2; end
    endcase
  end

  assign dsp_ins_flat = issue
    ? {DSP_XIN_MULT | DSP_ZIN_ZERO, op_a, op_b, 48'h0}
    : 92'h0;

  // Result must fit in acc[33:16]; any disagreement above bit 33 is overflow.
  always_comb begin
    y_sat = acc[33:16];
    if (!(&acc[47:33]) && (|acc[47:33]))
      y_sat = acc[47] ? 18'h20000 : 18'h1FFFF;
  end

  assign sample_out     = (state == OUT) ? y_sat : y_hold;
  assign sample_out_rdy = (state == OUT);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
      x0     <= '0;
      x1     <= '0;
      x2     <= '0;
      y1     <= '0;
      y2     <= '0;
      acc    <= '0;
      vld    <= '0;
      neg    <= '0;
      y_hold <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 3'd0 : cnt + 3'd1;
      if (coefs_update) shadow <= coefs_flat;
      vld <= {vld[1:0], issue};
      neg <= {neg[1:0], issue && (cnt == 3'd4)};
      if (accept) begin
        x0     <= sample_in;
        acc    <= '0;
        active <= coefs_update ? coefs_flat : shadow;
      end else if (vld[2]) begin
        acc <= neg[2] ? acc - dsp_outs_flat : acc + dsp_outs_flat;
      end
      if (state == OUT) begin
        y_hold <= y_sat;
        x2     <= x1;
        x1     <= x0;
        y2     <= y1;
        y1     <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_module_lpf_biquad.sv
// Directed bench for module_lpf_biquad with a 3-cycle multiply DSP model.
// Expected outputs are hand-computed Q1.16 values.
module tb_module_lpf_biquad;

  logic        clk = 1'b0;
  logic        reset;
  logic [89:0] coefs_flat;
  logic        coefs_update;
  logic [17:0] sample_in;
  logic        sample_in_rdy;
  logic [17:0] sample_out;
  logic        sample_out_rdy;
  logic        busy;
  logic [47:0] dsp_outs_flat;
  logic [91:0] dsp_ins_flat;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  module_lpf_biquad dut (
    .clk            (clk),
    .reset          (reset),
    .coefs_flat     (coefs_flat),
    .coefs_update   (coefs_update),
    .sample_in      (sample_in),
    .sample_in_rdy  (sample_in_rdy),
    .sample_out     (sample_out),
    .sample_out_rdy (sample_out_rdy),
    .busy           (busy),
    .dsp_outs_flat  (dsp_outs_flat),
    .dsp_ins_flat   (dsp_ins_flat)
  );

  logic signed [17:0] ma, mb;
  logic signed [47:0] p1 = '0, p2 = '0, p3 = '0;
  assign ma = dsp_ins_flat[83:66];
  assign mb = dsp_ins_flat[65:48];
  assign dsp_outs_flat = p3;

  always_ff @(posedge clk) begin
    p1 <= (dsp_ins_flat[91:84] == 8'h01) ? ma * mb : 48'sd0;
    p2 <= p1;
    p3 <= p2;
  end

  function automatic logic [89:0] cf(input logic [17:0] c0, c1, c2, c3, c4);
    return {c0, c1, c2, c3, c4};
  endfunction

  task automatic chk(input logic [91:0] obs, input logic [91:0] exp, input string tag);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [89:0] c);
    coefs_flat   = c;
    coefs_update = 1'b1;
    tick();
    coefs_update = 1'b0;
  endtask

  // Sample driven in cycle k; loop iteration i inspects cycle k+i.
  task automatic run(input logic [17:0] x, input logic [17:0] c2e,
                     input logic [17:0] exp_y, input string tag,
                     input int upd_cyc, input logic [89:0] upd_c,
                     input int rdy_cyc, input int rst_cyc);
    sample_in     = x;
    sample_in_rdy = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      sample_in_rdy = 1'b0;
      coefs_update  = 1'b0;
      reset         = 1'b0;
      if (rst_cyc == 0) begin
        chk({91'd0, busy}, 92'd1, {tag, "_busy"});
        chk({91'd0, sample_out_rdy}, {91'd0, i == 9}, {tag, "_rdy"});
        if (i == 1)
          chk(dsp_ins_flat, {8'h01, c2e, x, 48'h0}, {tag, "_issue"});
        if (i == 6)
          chk(dsp_ins_flat, 92'h0, {tag, "_drain_bus"});
        if (i == 9)
          chk({74'd0, sample_out}, {74'd0, exp_y}, {tag, "_y"});
      end else begin
        chk({91'd0, sample_out_rdy}, 92'd0, {tag, "_abort_rdy"});
      end
      if (i + 1 == upd_cyc) begin
        coefs_flat   = upd_c;
        coefs_update = 1'b1;
      end
      if (i + 1 == rdy_cyc) sample_in_rdy = 1'b1;
      if (i + 1 == rst_cyc) reset = 1'b1;
      tick();
    end
    sample_in_rdy = 1'b0;
    coefs_update  = 1'b0;
    reset         = 1'b0;
    chk({90'd0, busy, sample_out_rdy}, 92'd0, {tag, "_idle"});
    if (rst_cyc == 0)
      chk({74'd0, sample_out}, {74'd0, exp_y}, {tag, "_hold"});
  endtask

  initial begin
    reset         = 1'b1;
    coefs_flat    = '0;
    coefs_update  = 1'b0;
    sample_in     = '0;
    sample_in_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      chk({sample_out, sample_out_rdy, busy, 72'd0}, 92'd0, "reset_out");
      chk(dsp_ins_flat, 92'h0, "reset_bus");
      tick();
    end

    load(cf(18'h0, 18'h0, 18'h10000, 18'h0, 18'h0));
    run(18'h08000, 18'h10000, 18'h08000, "unity", 0, '0, 0, 0);

    do_reset();
    load(cf(18'h0, 18'h0, 18'h0, 18'h10000, 18'h0));
    run(18'h04000, 18'h0, 18'h00000, "delay1_a", 0, '0, 0, 0);
    run(18'h00000, 18'h0, 18'h04000, "delay1_b", 0, '0, 0, 0);

    do_reset();
    load(cf(18'h10000, 18'h0, 18'h10000, 18'h0, 18'h0));
    run(18'h1FFFF, 18'h10000, 18'h1FFFF, "satpos_a", 0, '0, 0, 0);
    run(18'h1FFFF, 18'h10000, 18'h1FFFF, "satpos_b", 0, '0, 0, 0);

    do_reset();
    load(cf(18'h10000, 18'h0, 18'h10000, 18'h0, 18'h0));
    run(18'h20000, 18'h10000, 18'h20000, "satneg_a", 0, '0, 0, 0);
    run(18'h20000, 18'h10000, 18'h20000, "satneg_b", 0, '0, 0, 0);

    do_reset();
    load(cf(18'h0, 18'h0, 18'h10000, 18'h0, 18'h0));
    run(18'h08000, 18'h10000, 18'h08000, "shadow_a", 3,
        cf(18'h0, 18'h0, 18'h08000, 18'h0, 18'h0), 4, 0);
    run(18'h08000, 18'h08000, 18'h04000, "shadow_b", 0, '0, 0, 0);

    run(18'h08000, 18'h08000, 18'h0, "abort", 0, '0, 0, 4);
    chk({74'd0, sample_out}, 92'd0, "abort_out_cleared");
    load(cf(18'h0, 18'h0, 18'h0, 18'h0, 18'h10000));
    run(18'h08000, 18'h0, 18'h00000, "hist_cleared", 0, '0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/module_lpf_biquad.md
MODULE_LPF_BIQUAD -- requirements
Module: module_lpf_biquad

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 coefs_flat  in  90  {c0,c1,c2,c3,c4}, each signed 18-bit, c0 in [89:72], c4 in [17:0], 0x10000 = 1.0.
REQ-005 coefs_update  in  1  one-cycle strobe; coefs_flat valid this cycle (driven by coefficient calculator calc_done).
REQ-006 sample_in  in  18  signed Q1.16 input sample.
REQ-007 sample_in_rdy  in  1  one-cycle strobe; sample_in valid this cycle.
REQ-008 sample_out  out  18  signed Q1.16 filtered sample.
REQ-009 sample_out_rdy  out  1  one-cycle strobe; sample_out valid this cycle.
REQ-010 busy  out  1  high from cycle after accepted sample_in_rdy until sample_out_rdy cycle inclusive.
REQ-011 dsp_outs_flat  in  48  shared DSP P output.
REQ-012 dsp_ins_flat  out  92  {opmode[7:0], a[17:0], b[17:0], c[47:0]} to shared DSP OR-bus.

Function
REQ-013 Transfer: y[n] = c2*x[n] + c3*x[n-1] + c4*x[n-2] + c0*y[n-1] - c1*y[n-2].
REQ-014 Coefficient shadow: coefs_update latches coefs_flat into shadow register in any state; shadow copied to active set on the cycle a sample is accepted; an in-flight sample always uses the active set.
REQ-015 Simultaneous coefs_update and sample_in_rdy: new coefficients apply to that sample.
REQ-016 FSM states IDLE, ISSUE, DRAIN, OUT; reset enters IDLE.
REQ-017 IDLE: sample_in_rdy=1 at edge k -> latch x, clear 48-bit accumulator, go ISSUE.
REQ-018 ISSUE: cycles k+1..k+5 issue products in order c2*x, c3*x1, c4*x2, c0*y1, c1*y2; opmode = `DSP_XIN_MULT | `DSP_ZIN_ZERO, a = coefficient, b = data, c = 0.
REQ-019 DSP latency: product of operands issued in cycle n is on dsp_outs_flat in cycle n+3; a 3-stage valid/sign shift register tracks it.
REQ-020 Accumulate: full 48-bit product added to the accumulator at end of its cycle; c1 term subtracted; last accumulate at end of cycle k+8.
REQ-021 DRAIN: cycles k+6..k+8, no DSP issue; OUT at cycle k+9.
REQ-022 Output: sample_out = acc[33:16] saturated: if acc[47:33] not all equal, output 0x1FFFF (acc positive) or 0x20000 (acc negative); sample_out_rdy=1 for exactly cycle k+9; latency 9 clocks.
REQ-023 sample_out holds its value until the next OUT; sample_out_rdy low otherwise.
REQ-024 History update at OUT: x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
REQ-025 sample_in_rdy while busy=1 is ignored; no queueing, no state change.
REQ-026 dsp_ins_flat = 92'h0 in every cycle not issuing a product (OR-bus rule).
REQ-027 Back-to-back: sample_in_rdy in the cycle after sample_out_rdy is accepted normally.

Reset
REQ-028 Reset: state IDLE; sample_out=0, sample_out_rdy=0, busy=0, dsp_ins_flat=0.
REQ-029 Reset clears active and shadow coefficients, accumulator, x1, x2, y1, y2 and the latency pipeline.
REQ-030 Reset mid-operation aborts the sample: no sample_out_rdy, and history is not updated from that sample.

Verification
REQ-031 Reset, then idle 20 cycles -> all outputs 0, dsp_ins_flat 0 every cycle.
REQ-032 coefs c2=0x10000, others 0; sample_in=0x08000 at cycle k -> sample_out=0x08000, single sample_out_rdy pulse at k+9, busy high k+1..k+9.
REQ-033 coefs c3=0x10000 only; samples 0x04000 then 0x00000 -> outputs 0x00000 then 0x04000.
REQ-034 coefs c2=0x10000, c0=0x10000; sample_in=0x1FFFF twice -> outputs 0x1FFFF then 0x1FFFF (saturated); repeat with 0x20000 -> 0x20000.
REQ-035 coefs_update with c2=0x08000 at k+3 during a c2=0x10000 sample of 0x08000 -> output 0x08000; next sample 0x08000 -> 0x04000; sample_in_rdy at k+4 produces no extra output.
REQ-036 reset asserted at k+4 -> no sample_out_rdy; next sample with c4=0x10000 only -> output 0 (history cleared).
